sap_program_ram: RTL and testbench
==================================

# sap_program_ram

Parametrised single-clock program/data RAM for the SAP CPU, the writable successor to the fixed 16x8 ROM. It adds a CPU write port for store instructions and a byte-stream programming port that loads a program sequentially through a ready/valid handshake. A self-clearing sequencer zeroes the whole array after every reset. It sits between the CPU's memory address register and bus, with the programming port driven by the board-level loader.

## Interface
- DATA_WIDTH, 8, word width in bits
- DEPTH, 16, number of words; must be a power of two, at least 2
- ADDR_WIDTH, 4, address width; must equal log2(DEPTH)

- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- readEnable  in  1  CPU read request
- readAddress  in  ADDR_WIDTH  CPU read address
- dataOut  out  DATA_WIDTH  registered read data
- dataValid  out  1  one-cycle pulse; dataOut was updated on this edge
- writeEnable  in  1  CPU write request
- writeAddress  in  ADDR_WIDTH  CPU write address
- writeData  in  DATA_WIDTH  CPU write data
- progMode  in  1  level; request or hold programming mode
- progValid  in  1  programming byte valid
- progData  in  DATA_WIDTH  programming byte
- progReady  out  1  block accepts progData this cycle
- progDone  out  1  all DEPTH words loaded
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLEAR, RUN, LOAD, DONE. A clock edge with reset high forces state CLEAR and sets clrPtr=0, loadPtr=0, dataOut=0, dataValid=0.
- Reset values of outputs: dataOut=0, dataValid=0, progReady=0, progDone=0, busy=1.
- Output decoding: busy=(state==CLEAR); progReady=(state==LOAD); progDone=(state==DONE). All three are decoded combinationally from state.
- CLEAR:
  - Each edge writes 0 to mem[clrPtr] and increments clrPtr.
  - After the write to DEPTH-1, the state moves to RUN.
  - CPU read/write and programming inputs are ignored; dataValid stays 0.
- RUN:
  - readEnable=1: dataOut<=mem[readAddress] and dataValid<=1. Otherwise dataOut holds and dataValid<=0.
  - writeEnable=1: mem[writeAddress]<=writeData.
  - A simultaneous read and write to the same address is read-first: dataOut gets the old word.
  - progMode=1: the state moves to LOAD and loadPtr<=0. CPU requests on that same edge are still serviced.
- LOAD:
  - On progValid&progReady, mem[loadPtr]<=progData and loadPtr increments.
  - The accepted write to DEPTH-1 moves the state to DONE; loadPtr wraps to 0.
  - progMode=0 before completion moves the state to RUN. Words already loaded are kept; the remaining words are unchanged.
  - The CPU ports are ignored and dataValid=0.
  - If progMode falls on the same edge as a valid transfer, the byte is written, then the state moves to RUN.
- DONE:
  - Holds progDone=1 while progMode=1. Further progValid is ignored.
  - progMode=0 moves the state to RUN.
- Reset has priority over every state, including mid-LOAD and mid-CLEAR. The array is then fully re-cleared.
- Address inputs are ADDR_WIDTH bits wide, so out-of-range addresses are impossible. loadPtr and clrPtr wrap modulo DEPTH.
- Memory contents are not reset directly; only the CLEAR sequence zeroes them.

## Timing
- Clear duration: with reset sampled low on edge 0 (the first edge after release), edges 0..DEPTH-1 perform the clear writes. busy=0 and RUN begin after edge DEPTH-1, i.e. DEPTH cycles after reset release.
- Read latency is 1 cycle: a request sampled on edge N drives dataOut and dataValid=1 after edge N. A read on the cycle after a write to the same address returns the new data.
- LOAD entry is 1 cycle: progMode sampled on edge N gives progReady=1 after edge N.
- Programming throughput is one byte per cycle while progValid is held.
- A full load takes DEPTH accepted transfers. progDone rises after the edge that accepts the last byte.
- progReady falls on the same edge that progDone rises.

## Test plan
- Reset clear: preload garbage via writes, then pulse reset for 1 cycle. Required: busy=1 for exactly 16 cycles, then reading addresses 0..15 returns 0x00 each with a 1-cycle dataValid.
- Full program load: progMode=1, stream 0x09,0xEF,0x1A,...,0xFF (16 bytes) with progValid held. Required: progReady drops and progDone=1 after the 16th byte; after progMode=0, reads return the stream in order.
- Throttled and aborted load: send 5 bytes with gaps in progValid, then drop progMode. Required: words 0..4 are loaded, words 5..15 are unchanged (0x00), and the state is RUN.
- CPU write/read: write 0xA5 to addr 7, and in the same cycle read addr 7. Required: dataOut is the old value (0x00); the next read of addr 7 gives 0xA5.
- Reset mid-load: after 8 bytes are accepted, assert reset. Required: progReady=0, progDone=0, busy=1 for 16 cycles, and all words read back 0x00.
- Parameter sweep: DATA_WIDTH=16, DEPTH=64, ADDR_WIDTH=6. Required: clear takes 64 cycles and a full 64-word load completes with progDone=1.

Source files
------------

// File: rtl/sap_program_ram.sv
// sap_program_ram: single-clock SAP program/data RAM with a CPU read/write port,
// a sequential byte-stream programming port and a self-clearing sequencer that
// zeroes the whole array after every reset.
module sap_program_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // CPU read port
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  // CPU write port
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  // Programming port
  input  logic                  progMode,
  input  logic                  progValid,
  input  logic [DATA_WIDTH-1:0] progData,
  output logic                  progReady,
  output logic                  progDone,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                  state_q,    state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q,  clr_ptr_d;
  logic [ADDR_WIDTH-1:0]   load_ptr_q, load_ptr_d;
  logic [DATA_WIDTH-1:0]   dout_q,     dout_d;
  logic                    dvalid_q,   dvalid_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // State, pointers and read data register; reset restarts the clear sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      load_ptr_q <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      load_ptr_q <= load_ptr_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
    end
  end

  // Storage array: exactly one write source per cycle, selected by the FSM
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state, pointer and write-port decode
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    load_ptr_d = load_ptr_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Read samples the array before this edge's write: read-first
        if (readEnable) begin
          dout_d   = mem_q[readAddress];
          dvalid_d = 1'b1;
        end
        if (writeEnable) begin
          mem_we    = 1'b1;
          mem_waddr = writeAddress;
          mem_wdata = writeData;
        end
        if (progMode) begin
          state_d    = ST_LOAD;
          load_ptr_d = '0;
        end
      end

      ST_LOAD: begin
        if (progValid) begin
          mem_we     = 1'b1;
          mem_waddr  = load_ptr_q;
          mem_wdata  = progData;
          load_ptr_d = load_ptr_q + ADDR_WIDTH'(1);
          if (load_ptr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end
        end
        // Leaving programming mode wins; a byte on this edge is still stored
        if (!progMode) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (!progMode) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign dataOut   = dout_q;
  assign dataValid = dvalid_q;
  assign busy      = (state_q == ST_CLEAR);
  assign progReady = (state_q == ST_LOAD);
  assign progDone  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sap_program_ram.sv
// Self-checking bench for sap_program_ram: default 16x8 instance exercised with
// randomized CPU traffic and program loads against an array model, plus a
// 64x16 instance for the wide/deep configuration.
module tb_sap_program_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- default instance: 16 x 8 ----------------
  logic       a_reset = 1'b1;
  logic       a_readEnable = 1'b0, a_writeEnable = 1'b0;
  logic [3:0] a_readAddress = '0, a_writeAddress = '0;
  logic [7:0] a_writeData = '0, a_progData = '0;
  logic       a_progMode = 1'b0, a_progValid = 1'b0;
  logic [7:0] a_dataOut;
  logic       a_dataValid, a_progReady, a_progDone, a_busy;

  sap_program_ram #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut_a (
    .clk(clk), .reset(a_reset),
    .readEnable(a_readEnable), .readAddress(a_readAddress),
    .dataOut(a_dataOut), .dataValid(a_dataValid),
    .writeEnable(a_writeEnable), .writeAddress(a_writeAddress), .writeData(a_writeData),
    .progMode(a_progMode), .progValid(a_progValid), .progData(a_progData),
    .progReady(a_progReady), .progDone(a_progDone), .busy(a_busy)
  );

  // ---------------- wide instance: 64 x 16 ----------------
  logic        b_reset = 1'b1;
  logic        b_readEnable = 1'b0, b_writeEnable = 1'b0;
  logic [5:0]  b_readAddress = '0, b_writeAddress = '0;
  logic [15:0] b_writeData = '0, b_progData = '0;
  logic        b_progMode = 1'b0, b_progValid = 1'b0;
  logic [15:0] b_dataOut;
  logic        b_dataValid, b_progReady, b_progDone, b_busy;

  sap_program_ram #(.DATA_WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6)) dut_b (
    .clk(clk), .reset(b_reset),
    .readEnable(b_readEnable), .readAddress(b_readAddress),
    .dataOut(b_dataOut), .dataValid(b_dataValid),
    .writeEnable(b_writeEnable), .writeAddress(b_writeAddress), .writeData(b_writeData),
    .progMode(b_progMode), .progValid(b_progValid), .progData(b_progData),
    .progReady(b_progReady), .progDone(b_progDone), .busy(b_busy)
  );

  // Reference state: array contents and last returned read word
  logic [7:0]  model_a [16];
  logic [7:0]  exp_dout_a;
  logic [15:0] model_b [64];
  logic [7:0]  stream  [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_readEnable = 1'b0; a_writeEnable = 1'b0;
    a_progMode = 1'b0; a_progValid = 1'b0;
  endtask

  // Pulse reset for one edge and measure how long the clear sequence runs
  task automatic reset_a(input string tag);
    int cycles;
    a_reset = 1'b1;
    tick();
    check({tag, "_busy"},  32'(a_busy), 32'd1);
    check({tag, "_ready"}, 32'(a_progReady), 32'd0);
    check({tag, "_done"},  32'(a_progDone), 32'd0);
    check({tag, "_dout"},  32'(a_dataOut), 32'd0);
    check({tag, "_dval"},  32'(a_dataValid), 32'd0);
    a_reset = 1'b0;
    idle_a();
    cycles = 0;
    while (a_busy && cycles < 100) begin
      tick();
      cycles++;
    end
    check({tag, "_clear_cycles"}, 32'(cycles), 32'd16);
    for (int i = 0; i < 16; i++) model_a[i] = 8'h00;
    exp_dout_a = 8'h00;
  endtask

  // One CPU cycle in RUN; read-first against the model, then apply the write
  task automatic cpu_op(input string tag, input bit re, input logic [3:0] ra,
                        input bit we, input logic [3:0] wa, input logic [7:0] wd);
    a_readEnable = re; a_readAddress = ra;
    a_writeEnable = we; a_writeAddress = wa; a_writeData = wd;
    tick();
    a_readEnable = 1'b0; a_writeEnable = 1'b0;
    if (re) exp_dout_a = model_a[ra];
    check({tag, "_dval"}, 32'(a_dataValid), 32'(re));
    check({tag, "_dout"}, 32'(a_dataOut), 32'(exp_dout_a));
    if (we) model_a[wa] = wd;
  endtask

  task automatic read_all_a(input string tag);
    for (int i = 0; i < 16; i++) cpu_op(tag, 1'b1, 4'(i), 1'b0, 4'd0, 8'd0);
  endtask

  // Stream nbytes of `stream` into the programming port; CPU noise is driven
  // throughout and must be ignored. A full load is left in DONE for the caller.
  task automatic load_a(input string tag, input int nbytes, input bit gaps);
    int ptr, cyc;
    bit v;
    a_progMode = 1'b1;
    tick();
    check({tag, "_entry_ready"}, 32'(a_progReady), 32'd1);
    ptr = 0;
    cyc = 0;
    while (ptr < nbytes && cyc < 300) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      a_progValid    = v;
      a_progData     = stream[ptr];
      a_readEnable   = 1'($urandom);
      a_readAddress  = 4'($urandom);
      a_writeEnable  = 1'($urandom);
      a_writeAddress = 4'($urandom);
      a_writeData    = 8'($urandom);
      tick();
      cyc++;
      if (v) begin
        model_a[ptr] = stream[ptr];
        ptr++;
      end
      check({tag, "_dval"}, 32'(a_dataValid), 32'd0);
      check({tag, "_ready"}, 32'(a_progReady), 32'(ptr < 16));
      check({tag, "_done"},  32'(a_progDone),  32'(ptr >= 16));
    end
    check({tag, "_accepted"}, 32'(ptr), 32'(nbytes));
    a_progValid = 1'b0; a_readEnable = 1'b0; a_writeEnable = 1'b0;
  endtask

  task automatic leave_prog_a(input string tag);
    a_progMode = 1'b0;
    a_progValid = 1'b0;
    tick();
    check({tag, "_busy"},  32'(a_busy), 32'd0);
    check({tag, "_ready"}, 32'(a_progReady), 32'd0);
    check({tag, "_done"},  32'(a_progDone), 32'd0);
    check({tag, "_dout_hold"}, 32'(a_dataOut), 32'(exp_dout_a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    idle_a();
    tick();

    // Power-up clear, then fill with garbage and prove reset re-clears it
    reset_a("por");
    for (int i = 0; i < 16; i++) cpu_op("garbage", 1'b0, 4'd0, 1'b1, 4'(i), 8'($urandom_range(1, 255)));
    read_all_a("garbage_rd");
    reset_a("rst_clear");
    read_all_a("rst_clear_rd");

    // Full program load with progValid held, extra bytes in DONE ignored
    stream[0] = 8'h09; stream[1] = 8'hEF; stream[2] = 8'h1A; stream[15] = 8'hFF;
    for (int i = 3; i < 15; i++) stream[i] = 8'($urandom);
    load_a("full", 16, 1'b0);
    a_progValid = 1'b1; a_progData = 8'h5A;
    tick();
    check("full_done_hold", 32'(a_progDone), 32'd1);
    leave_prog_a("full_exit");
    read_all_a("full_rd");

    // Throttled load of 5 bytes, then abort
    reset_a("rst_abort");
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    load_a("abort", 5, 1'b1);
    leave_prog_a("abort_exit");
    read_all_a("abort_rd");

    // Read-first on a same-address read/write, then read-after-write
    cpu_op("raw_same", 1'b1, 4'd7, 1'b1, 4'd7, 8'hA5);
    cpu_op("raw_next", 1'b1, 4'd7, 1'b0, 4'd0, 8'h00);
    check("raw_value", 32'(a_dataOut), 32'hA5);

    // Random CPU traffic, addresses concentrated to force collisions
    for (int n = 0; n < 200; n++) begin
      logic [3:0] ra, wa;
      ra = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(4, 7));
      wa = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(4, 7));
      cpu_op("rand", 1'($urandom), ra, 1'($urandom), wa, 8'($urandom));
    end
    read_all_a("rand_rd");

    // Reset in the middle of a load
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom_range(1, 255));
    load_a("midload", 8, 1'b0);
    a_progValid = 1'b1; a_progData = 8'hCC;
    reset_a("rst_mid");
    read_all_a("rst_mid_rd");

    // Wide/deep configuration: 64-cycle clear and a 64-word load
    b_reset = 1'b1;
    tick();
    check("b_rst_busy", 32'(b_busy), 32'd1);
    b_reset = 1'b0;
    cycles = 0;
    while (b_busy && cycles < 300) begin
      tick();
      cycles++;
    end
    check("b_clear_cycles", 32'(cycles), 32'd64);
    b_progMode = 1'b1;
    tick();
    check("b_entry_ready", 32'(b_progReady), 32'd1);
    for (int i = 0; i < 64; i++) begin
      model_b[i] = 16'($urandom);
      b_progValid = 1'b1;
      b_progData  = model_b[i];
      tick();
      if (i == 63 || i == 62) check("b_done_edge", 32'(b_progDone), 32'(i == 63));
    end
    check("b_ready_drop", 32'(b_progReady), 32'd0);
    b_progValid = 1'b0;
    b_progMode  = 1'b0;
    tick();
    check("b_exit_done", 32'(b_progDone), 32'd0);
    for (int k = 0; k < 12; k++) begin
      logic [5:0] ad;
      ad = (k < 2) ? 6'(k * 63) : 6'($urandom);
      b_readEnable = 1'b1;
      b_readAddress = ad;
      tick();
      b_readEnable = 1'b0;
      check("b_rd_dval", 32'(b_dataValid), 32'd1);
      check("b_rd_data", 32'(b_dataOut), 32'(model_b[ad]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
